// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port ideal-memory arbiter.
//   arb_state_e        : arbiter FSM encoding (idle / CPU response / host response)
//   StarveLimitDefault : default max consecutive CPU grants while the host waits
package mem_arb_pkg;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StRespCpu  = 2'd1,
      StRespHost = 2'd2
   } arb_state_e;

   localparam int unsigned StarveLimitDefault = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU port and a host port onto one ideal (combinational-read) memory.
// One transaction outstanding at a time; the CPU has priority unless the host has
// been passed over STARVE_LIMIT times in a row.
// Ports:
//   clk, resetn                     : clock, asynchronous active-low reset
//   cpu_req_*  / cpu_resp_*         : CPU request (valid/ready/wr/addr/wdata/wstrb), response
//   host_req_* / host_resp_*        : host request (no strobe, full-word writes), response
//   mem_addr/wren/rden/wdata/wstrb  : access to ideal memory, issued in the grant cycle
//   mem_rdata                       : combinational read data from ideal memory
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 12,
   parameter int unsigned STARVE_LIMIT = StarveLimitDefault
) (
   input  logic                  clk,
   input  logic                  resetn,

   input  logic                  cpu_req_valid,
   output logic                  cpu_req_ready,
   input  logic                  cpu_req_wr,
   input  logic [ADDR_WIDTH-3:0] cpu_req_addr,
   input  logic [31:0]           cpu_req_wdata,
   input  logic [3:0]            cpu_req_wstrb,
   output logic                  cpu_resp_valid,
   input  logic                  cpu_resp_ready,
   output logic [31:0]           cpu_resp_rdata,

   input  logic                  host_req_valid,
   output logic                  host_req_ready,
   input  logic                  host_req_wr,
   input  logic [ADDR_WIDTH-3:0] host_req_addr,
   input  logic [31:0]           host_req_wdata,
   output logic                  host_resp_valid,
   input  logic                  host_resp_ready,
   output logic [31:0]           host_resp_rdata,

   output logic [ADDR_WIDTH-3:0] mem_addr,
   output logic                  mem_wren,
   output logic                  mem_rden,
   output logic [31:0]           mem_wdata,
   output logic [3:0]            mem_wstrb,
   input  logic [31:0]           mem_rdata
);

   localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

   arb_state_e      state_q, state_d;
   logic [CntW-1:0] starve_q, starve_d;
   logic [31:0]     resp_q, resp_d;

   logic idle, host_sel, cpu_sel, cpu_grant, host_grant, grant, sel_wr;

   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      resp_d   = resp_q;

      idle = (state_q == StIdle);
      // Host wins when it is the only requester, or when it has been starved.
      host_sel = host_req_valid && (!cpu_req_valid || (starve_q == StarveMax));
      cpu_sel  = cpu_req_valid && !host_sel;

      // Gate with resetn so nothing is accepted while reset is held.
      cpu_req_ready  = resetn && idle && cpu_sel;
      host_req_ready = resetn && idle && host_sel;
      cpu_grant      = cpu_req_valid && cpu_req_ready;
      host_grant     = host_req_valid && host_req_ready;
      grant          = cpu_grant || host_grant;

      if (host_sel) begin
         mem_addr  = host_req_addr;
         mem_wdata = host_req_wdata;
         mem_wstrb = 4'b1111;
         sel_wr    = host_req_wr;
      end else begin
         mem_addr  = cpu_req_addr;
         mem_wdata = cpu_req_wdata;
         mem_wstrb = cpu_req_wstrb;
         sel_wr    = cpu_req_wr;
      end
      mem_wren = grant && sel_wr;
      mem_rden = grant && !sel_wr;

      case (state_q)
         StIdle: begin
            if (grant) begin
               resp_d  = sel_wr ? 32'h0 : mem_rdata;
               state_d = cpu_grant ? StRespCpu : StRespHost;
            end
         end
         StRespCpu:  if (cpu_resp_ready) state_d = StIdle;
         StRespHost: if (host_resp_ready) state_d = StIdle;
         default:    state_d = StIdle;
      endcase

      if (host_grant || !host_req_valid) begin
         starve_d = '0;
      end else if (cpu_grant && (starve_q != StarveMax)) begin
         starve_d = starve_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= StIdle;
         starve_q <= '0;
         resp_q   <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         resp_q   <= resp_d;
      end
   end

   assign cpu_resp_valid  = (state_q == StRespCpu);
   assign host_resp_valid = (state_q == StRespHost);
   assign cpu_resp_rdata  = resp_q;
   assign host_resp_rdata = resp_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised + directed bench for mem_arbiter with an ideal memory and a scoreboard.
module tb_mem_arbiter;

   localparam int AW    = 12;
   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        cpu_req_valid = 0, cpu_req_ready, cpu_req_wr = 0;
   logic [9:0]  cpu_req_addr = '0;
   logic [31:0] cpu_req_wdata = '0;
   logic [3:0]  cpu_req_wstrb = '0;
   logic        cpu_resp_valid, cpu_resp_ready = 1;
   logic [31:0] cpu_resp_rdata;
   logic        host_req_valid = 0, host_req_ready, host_req_wr = 0;
   logic [9:0]  host_req_addr = '0;
   logic [31:0] host_req_wdata = '0;
   logic        host_resp_valid, host_resp_ready = 1;
   logic [31:0] host_resp_rdata;
   logic [9:0]  mem_addr;
   logic        mem_wren, mem_rden;
   logic [31:0] mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;

   mem_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .resetn(resetn),
      .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_wr(cpu_req_wr),
      .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata), .cpu_req_wstrb(cpu_req_wstrb),
      .cpu_resp_valid(cpu_resp_valid), .cpu_resp_ready(cpu_resp_ready),
      .cpu_resp_rdata(cpu_resp_rdata),
      .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
      .host_req_wr(host_req_wr), .host_req_addr(host_req_addr),
      .host_req_wdata(host_req_wdata), .host_resp_valid(host_resp_valid),
      .host_resp_ready(host_resp_ready), .host_resp_rdata(host_resp_rdata),
      .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_rden(mem_rden),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Ideal memory environment
   logic [31:0] mem [1024];
   logic [31:0] shadow [1024];
   initial for (int i = 0; i < 1024; i++) begin mem[i] = '0; shadow[i] = '0; end
   assign mem_rdata = mem[mem_addr];
   always @(posedge clk)
      if (mem_wren)
         for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model / scoreboard state, owned by the monitor
   bit          busy = 0, busy_host = 0;
   int          starve = 0;
   logic [31:0] exp_cpu[$], exp_host[$];
   bit          grant_log[$];   // 0 = CPU, 1 = host
   bit          rr_rand = 0;

   always @(negedge clk) begin
      bit hw, cw, m_wr;
      logic [9:0] m_addr;
      logic [31:0] m_wdata, rd;
      logic [3:0] m_strb;
      if (!resetn) begin
         busy = 0; exp_cpu.delete(); exp_host.delete(); starve = 0;
         check("rst_cpu_ready", cpu_req_ready, 0);
         check("rst_host_ready", host_req_ready, 0);
         check("rst_mem_en", {mem_wren, mem_rden}, 0);
         check("rst_resp_valid", {cpu_resp_valid, host_resp_valid}, 0);
      end else if (!busy) begin
         hw = host_req_valid && (!cpu_req_valid || starve == LIMIT);
         cw = cpu_req_valid && !hw;
         check("cpu_req_ready", cpu_req_ready, cw);
         check("host_req_ready", host_req_ready, hw);
         check("idle_resp_valid", {cpu_resp_valid, host_resp_valid}, 0);
         if (cw || hw) begin
            if (hw) begin
               m_wr = host_req_wr; m_addr = host_req_addr; m_wdata = host_req_wdata;
               m_strb = 4'hf;
            end else begin
               m_wr = cpu_req_wr; m_addr = cpu_req_addr; m_wdata = cpu_req_wdata;
               m_strb = cpu_req_wstrb;
            end
            check("mem_wren", mem_wren, m_wr);
            check("mem_rden", mem_rden, !m_wr);
            check("mem_addr", mem_addr, m_addr);
            if (m_wr) begin
               check("mem_wstrb", mem_wstrb, m_strb);
               check("mem_wdata", mem_wdata, m_wdata);
            end
            rd = m_wr ? 32'h0 : shadow[m_addr];
            if (m_wr)
               for (int b = 0; b < 4; b++)
                  if (m_strb[b]) shadow[m_addr][8*b +: 8] = m_wdata[8*b +: 8];
            if (hw) exp_host.push_back(rd); else exp_cpu.push_back(rd);
            grant_log.push_back(hw);
            busy = 1; busy_host = hw;
            if (hw || !host_req_valid) starve = 0;
            else if (starve < LIMIT) starve++;
         end else begin
            check("idle_mem_en", {mem_wren, mem_rden}, 0);
            if (!host_req_valid) starve = 0;
         end
      end else begin
         check("busy_cpu_ready", cpu_req_ready, 0);
         check("busy_host_ready", host_req_ready, 0);
         check("busy_mem_en", {mem_wren, mem_rden}, 0);
         check("cpu_resp_valid", cpu_resp_valid, !busy_host);
         check("host_resp_valid", host_resp_valid, busy_host);
         if (!host_req_valid) starve = 0;
         if (!busy_host && cpu_resp_valid && exp_cpu.size() > 0) begin
            check("cpu_resp_rdata", cpu_resp_rdata, exp_cpu[0]);
            if (cpu_resp_ready) begin void'(exp_cpu.pop_front()); busy = 0; end
         end else if (busy_host && host_resp_valid && exp_host.size() > 0) begin
            check("host_resp_rdata", host_resp_rdata, exp_host[0]);
            if (host_resp_ready) begin void'(exp_host.pop_front()); busy = 0; end
         end
      end
   end

   // Random response back-pressure when enabled
   initial forever begin
      @(posedge clk); #1;
      if (rr_rand) begin
         cpu_resp_ready  = ($urandom_range(0, 3) != 0);
         host_resp_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Drivers: called at posedge+1, hold valid until accepted, return at posedge+1
   task automatic cpu_txn(input bit wr, input logic [9:0] a, input logic [31:0] d,
                          input logic [3:0] s);
      int n = 0;
      cpu_req_valid = 1; cpu_req_wr = wr; cpu_req_addr = a; cpu_req_wdata = d;
      cpu_req_wstrb = s;
      do begin @(negedge clk); n++; end while (!cpu_req_ready && n < 300);
      check("cpu_grant_wait", cpu_req_ready, 1);
      @(posedge clk); #1;
      cpu_req_valid = 0;
   endtask

   task automatic host_txn(input bit wr, input logic [9:0] a, input logic [31:0] d);
      int n = 0;
      host_req_valid = 1; host_req_wr = wr; host_req_addr = a; host_req_wdata = d;
      do begin @(negedge clk); n++; end while (!host_req_ready && n < 300);
      check("host_grant_wait", host_req_ready, 1);
      @(posedge clk); #1;
      host_req_valid = 0;
   endtask

   task automatic wait_cpu_resp(output logic [31:0] d);
      int n = 0;
      do begin @(negedge clk); n++; end while (!(cpu_resp_valid && cpu_resp_ready) && n < 300);
      check("cpu_resp_wait", cpu_resp_valid, 1);
      d = cpu_resp_rdata;
      @(posedge clk); #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin @(negedge clk); n++; end while ((busy || cpu_req_valid || host_req_valid)
                                               && n < 500);
      check("idle_wait", busy, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] d;
      logic [4:0]  pat;
      // Reset: a pending CPU request must not be accepted
      cpu_req_valid = 1;
      repeat (3) @(negedge clk);
      check("rst_ready_held", cpu_req_ready, 0);
      check("rst_wren_held", mem_wren | mem_rden, 0);
      @(posedge clk); #1 cpu_req_valid = 0;
      @(posedge clk); #2 resetn = 1;
      @(posedge clk); #1;

      // Write then read back
      cpu_txn(1, 10'h10, 32'hDEADBEEF, 4'hf);
      cpu_txn(0, 10'h10, 32'h0, 4'h0);
      wait_cpu_resp(d);
      check("readback_deadbeef", d, 32'hDEADBEEF);

      // Byte-strobe merge
      cpu_txn(1, 10'h20, 32'h11223344, 4'hf);
      cpu_txn(1, 10'h20, 32'h0000AB00, 4'b0010);
      cpu_txn(0, 10'h20, 32'h0, 4'h0);
      wait_cpu_resp(d);
      check("strobe_merge", d, 32'h1122AB44);

      // Simultaneous requests: CPU first, then host
      grant_log.delete();
      fork
         cpu_txn(0, 10'h10, 32'h0, 4'h0);
         host_txn(0, 10'h20, 32'h0);
      join
      wait_idle();
      check("both_valid_order", {30'h0, grant_log.size() > 1 ? grant_log[1] : 1'b0,
                                 grant_log.size() > 0 ? grant_log[0] : 1'b1}, 32'h2);

      // Starvation: host wins after exactly LIMIT CPU grants
      grant_log.delete();
      fork
         for (int i = 0; i < 7; i++) cpu_txn(0, 10'(i), 32'h0, 4'h0);
         host_txn(0, 10'h20, 32'h0);
      join
      wait_idle();
      pat = '1;
      for (int i = 0; i < 5; i++) if (i < grant_log.size()) pat[i] = grant_log[i];
      check("starve_order", pat, 5'b10000);
      check("starve_cpu_after", grant_log.size() > 5 ? grant_log[5] : 1'b1, 0);

      // Held response back-pressure
      cpu_resp_ready = 0;
      fork
         cpu_txn(0, 10'h20, 32'h0, 4'h0);
         host_txn(0, 10'h10, 32'h0);
         begin
            int n = 0;
            do begin @(negedge clk); n++; end while (!cpu_resp_valid && n < 50);
            for (int i = 0; i < 5; i++) begin
               if (i > 0) @(negedge clk);
               check("hold_valid", cpu_resp_valid, 1);
               check("hold_rdata", cpu_resp_rdata, 32'h1122AB44);
               check("hold_host_ready", host_req_ready, 0);
            end
            @(posedge clk); #1 cpu_resp_ready = 1;
         end
      join
      wait_idle();

      // Reset while a host response is pending
      host_resp_ready = 0;
      host_txn(0, 10'h10, 32'h0);
      check("pre_rst_host_valid", host_resp_valid, 1);
      #1 resetn = 0;
      #1;
      check("async_rst_host_valid", host_resp_valid, 0);
      check("async_rst_rdata", host_resp_rdata, 0);
      repeat (3) @(posedge clk);
      #2 resetn = 1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("no_stale_resp", host_resp_valid | cpu_resp_valid, 0);
      end
      @(posedge clk); #1 host_resp_ready = 1;

      // Randomised traffic on both ports
      rr_rand = 1;
      fork
         for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            cpu_txn(1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom,
                    4'($urandom_range(0, 15)));
         end
         for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            host_txn(1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom);
         end
      join
      wait_idle();
      rr_rand = 0;
      check("queues_drained", exp_cpu.size() + exp_host.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, byte-address width of ideal memory (word address is ADDR_WIDTH-2 bits).
REQ-002 Parameter STARVE_LIMIT, default 4, maximum consecutive CPU grants while host waits.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  single clock, all state rising-edge.
REQ-005 resetn  input  1  asynchronous active-low reset.
REQ-006 cpu_req_valid / cpu_req_ready  input / output  1 / 1  CPU request handshake.
REQ-007 cpu_req_wr  input  1  1 = write, 0 = read.
REQ-008 cpu_req_addr  input  ADDR_WIDTH-2  word address.
REQ-009 cpu_req_wdata / cpu_req_wstrb  input  32 / 4  write data, byte strobes.
REQ-010 cpu_resp_valid / cpu_resp_ready  output / input  1 / 1  CPU response handshake.
REQ-011 cpu_resp_rdata  output  32  read data (0 for write responses).
REQ-012 host_req_valid, host_req_ready, host_req_wr, host_req_addr, host_req_wdata, host_resp_valid, host_resp_ready, host_resp_rdata: same directions and widths as CPU port; no strobe, host writes use 4'b1111.
REQ-013 mem_addr  output  ADDR_WIDTH-2  shared word address to ideal memory.
REQ-014 mem_wren / mem_rden  output  1 / 1  write / read enable.
REQ-015 mem_wdata / mem_wstrb  output  32 / 4  write data, strobes.
REQ-016 mem_rdata  input  32  combinational read data, valid in same cycle as mem_rden.

Function
REQ-017 FSM states IDLE, RESP_CPU, RESP_HOST.
REQ-018 cpu_req_ready = host_req_ready = 0 outside IDLE; in IDLE, ready asserted only toward the port selected by REQ-020.
REQ-019 Grant occurs in IDLE on the cycle valid&ready; memory access (mem_wren or mem_rden) issued combinationally in that same cycle from the granted port; all mem_* enables 0 otherwise.
REQ-020 Priority: CPU over host, except when starve counter == STARVE_LIMIT and both valid -> host granted.
REQ-021 Starve counter (width clog2(STARVE_LIMIT+1)): +1 on CPU grant while host_req_valid; cleared on host grant or when host_req_valid = 0; saturates at STARVE_LIMIT.
REQ-022 On grant, rdata (reads) or 0 (writes) latched into response register; FSM -> RESP_CPU / RESP_HOST; resp_valid of that port = 1 next cycle (latency 1).
REQ-023 resp_valid held with stable rdata until resp_ready; on valid&ready FSM -> IDLE; earliest next grant the following cycle (max throughput 1 per 2 cycles).
REQ-024 Only one transaction outstanding; the non-granted port's valid is ignored, not lost (requester holds valid).
REQ-025 Simultaneous CPU write and host read of same address: only one granted per REQ-020; no contention possible.
REQ-026 Write strobe byte-masking performed by ideal memory; arbiter passes strobes unchanged.

Reset
REQ-027 resetn low: FSM -> IDLE, starve counter -> 0, response register -> 0, all resp_valid -> 0, immediately (asynchronous).
REQ-028 During reset all req_ready and mem_* enables = 0.
REQ-029 Reset during RESP_*: pending response discarded; no response issued after release.

Structure
REQ-030 FSM state encoding and default STARVE_LIMIT live in shared package mem_arb_pkg.
REQ-031 Single module; no sub-module required (priority/starve logic inline).

Verification
REQ-032 CPU write addr 0x10 data 0xDEADBEEF strb 4'b1111, then read 0x10 -> mem_wren 1 cycle, read resp next cycle rdata 0xDEADBEEF.
REQ-033 CPU and host both valid from IDLE, reads -> CPU granted first, host granted after CPU response handshake.
REQ-034 CPU valid continuously, host valid, STARVE_LIMIT 4 -> host granted after exactly 4 CPU grants; counter returns to 0.
REQ-035 cpu_resp_ready held low 5 cycles -> cpu_resp_valid and rdata stable 5 cycles, no new grant, host_req_ready 0.
REQ-036 resetn asserted in RESP_HOST -> host_resp_valid 0 same cycle; after release, IDLE, no stale response.
REQ-037 CPU write strb 4'b0010 data 0x0000AB00 over 0x11223344 -> subsequent read returns 0x1122AB44.
